// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, ALU control codes
// and forwarding-mux select codes used by the execute stage.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int REG_W   = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_MUL = 3'b111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_W      = 2'b01,
    FWD_M      = 2'b10,
    FWD_RF_ALT = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/execute_cycle_if.sv
// E-stage input bundle and EX/MEM output bundle of the execute stage.
// master: decode/hazard side driving E-stage values; slave: execute_cycle.
interface execute_cycle_if;
  import riscv_pkg::*;

  logic             RegWriteE;
  logic             MemWriteE;
  logic             ResultSrcE;
  logic             BranchE;
  logic             JumpE;
  logic             ALUSrcE;
  logic [2:0]       ALUControlE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [XLEN-1:0]  RD1_E;
  logic [XLEN-1:0]  RD2_E;
  logic [XLEN-1:0]  Imm_Ext_E;
  logic [XLEN-1:0]  PCE;
  logic [XLEN-1:0]  PCPlus4E;
  logic [XLEN-1:0]  ResultW;
  logic [REG_W-1:0] RD_E;

  logic             PCSrcE;
  logic [XLEN-1:0]  PCTargetE;
  logic             BusyE;

  logic             RegWriteM;
  logic             MemWriteM;
  logic             ResultSrcM;
  logic [REG_W-1:0] RD_M;
  logic [XLEN-1:0]  PCPlus4M;
  logic [XLEN-1:0]  WriteDataM;
  logic [XLEN-1:0]  ALU_ResultM;

  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE,
    output ALUControlE, ForwardAE, ForwardBE,
    output RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, RD_E,
    input  PCSrcE, PCTargetE, BusyE,
    input  RegWriteM, MemWriteM, ResultSrcM, RD_M,
    input  PCPlus4M, WriteDataM, ALU_ResultM
  );

  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE,
    input  ALUControlE, ForwardAE, ForwardBE,
    input  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, RD_E,
    output PCSrcE, PCTargetE, BusyE,
    output RegWriteM, MemWriteM, ResultSrcM, RD_M,
    output PCPlus4M, WriteDataM, ALU_ResultM
  );

endinterface

// File: rtl/seq_multiplier.sv
// Shift-add sequential multiplier, one multiplier bit per cycle.
// IDLE latches operands on start; BUSY runs DATA_W iterations; DONE presents
// the low DATA_W bits of the product for one cycle, then returns to IDLE.
module seq_multiplier
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;

  // Sequencer and shift-add datapath; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Busy covers the launch cycle in IDLE so the stall begins immediately.
  always_comb begin
    busy    = ((state == ST_IDLE) && start) || (state == ST_BUSY);
    done    = (state == ST_DONE);
    product = acc;
  end

endmodule

// File: rtl/execute_cycle.sv
// RISC-V execute stage: operand forwarding, ALU, branch/jump resolution and
// the EX/MEM pipeline register. Optional sequential MUL enabled by the
// EX_MUL_EN macro; without it code 111 produces 0 and BusyE stays low.
module execute_cycle
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  execute_cycle_if.slave ex
);

  logic [XLEN-1:0]  src_a;
  logic [XLEN-1:0]  fwd_b;
  logic [XLEN-1:0]  src_b;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  mul_result;
  logic             zero;
  logic             busy;
  logic             is_mul;

  logic             reg_write_p1;
  logic             mem_write_p1;
  logic             result_src_p1;
  logic [REG_W-1:0] rd_p1;
  logic [XLEN-1:0]  pc_plus4_p1;
  logic [XLEN-1:0]  write_data_p1;
  logic [XLEN-1:0]  alu_result_p1;

  function automatic logic [XLEN-1:0] alu_op(input logic [2:0]      ctl,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b,
                                             input logic [XLEN-1:0] mul);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (ctl)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLL: return a << b[SHAMT_W-1:0];
      default: return mul;
    endcase
  endfunction

  // Operand forwarding muxes and immediate select.
  always_comb begin
    case (ex.ForwardAE)
      FWD_W:   src_a = ex.ResultW;
      FWD_M:   src_a = alu_result_p1;
      default: src_a = ex.RD1_E;
    endcase
    case (ex.ForwardBE)
      FWD_W:   fwd_b = ex.ResultW;
      FWD_M:   fwd_b = alu_result_p1;
      default: fwd_b = ex.RD2_E;
    endcase
    src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b;
  end

  assign is_mul = (ex.ALUControlE == ALU_MUL);

`ifdef EX_MUL_EN
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  seq_multiplier #(.DATA_W(XLEN)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (is_mul),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign busy       = mul_busy;
  assign mul_result = mul_done ? mul_product : '0;
`else
  assign busy       = 1'b0;
  assign mul_result = '0;
`endif

  // ALU, branch decision and redirect target.
  always_comb begin
    alu_result   = alu_op(ex.ALUControlE, src_a, src_b, mul_result);
    zero         = (alu_result == '0);
    ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;
    ex.PCSrcE    = !is_mul && (ex.JumpE || (ex.BranchE && zero));
    ex.BusyE     = busy;
  end

  // ---- E -> M stage boundary ----
  // EX/MEM register: captures E-stage values, or a bubble while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_p1  <= 1'b0;
      mem_write_p1  <= 1'b0;
      result_src_p1 <= 1'b0;
      rd_p1         <= '0;
      pc_plus4_p1   <= '0;
      write_data_p1 <= '0;
      alu_result_p1 <= '0;
    end else if (busy) begin
      reg_write_p1  <= 1'b0;
      mem_write_p1  <= 1'b0;
      result_src_p1 <= 1'b0;
      rd_p1         <= '0;
      pc_plus4_p1   <= '0;
      write_data_p1 <= '0;
      alu_result_p1 <= '0;
    end else begin
      reg_write_p1  <= ex.RegWriteE;
      mem_write_p1  <= ex.MemWriteE;
      result_src_p1 <= ex.ResultSrcE;
      rd_p1         <= ex.RD_E;
      pc_plus4_p1   <= ex.PCPlus4E;
      write_data_p1 <= fwd_b;
      alu_result_p1 <= alu_result;
    end
  end

  assign ex.RegWriteM   = reg_write_p1;
  assign ex.MemWriteM   = mem_write_p1;
  assign ex.ResultSrcM  = result_src_p1;
  assign ex.RD_M        = rd_p1;
  assign ex.PCPlus4M    = pc_plus4_p1;
  assign ex.WriteDataM  = write_data_p1;
  assign ex.ALU_ResultM = alu_result_p1;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle with an EX/MEM scoreboard.
// Exercises the EX_MUL_EN path when that macro is defined.
module tb_execute_cycle;
  import riscv_pkg::*;

  typedef struct packed {
    logic        regw;
    logic        memw;
    logic        rsrc;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] wd;
    logic [31:0] alu;
  } exp_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  exp_t exp_q[$];

  execute_cycle_if bus();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.RegWriteE   = 1'b0;
    bus.MemWriteE   = 1'b0;
    bus.ResultSrcE  = 1'b0;
    bus.BranchE     = 1'b0;
    bus.JumpE       = 1'b0;
    bus.ALUSrcE     = 1'b0;
    bus.ALUControlE = ALU_ADD;
    bus.ForwardAE   = FWD_RF;
    bus.ForwardBE   = FWD_RF;
    bus.RD1_E       = '0;
    bus.RD2_E       = '0;
    bus.Imm_Ext_E   = '0;
    bus.PCE         = '0;
    bus.PCPlus4E    = '0;
    bus.ResultW     = '0;
    bus.RD_E        = '0;
  endtask

  task automatic op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                    input logic regw, input logic [4:0] rd, input logic [31:0] pc4);
    bus.ALUControlE = ctl;
    bus.RD1_E       = a;
    bus.RD2_E       = b;
    bus.RegWriteE   = regw;
    bus.RD_E        = rd;
    bus.PCPlus4E    = pc4;
  endtask

  task automatic expect_m(input logic regw, input logic memw, input logic rsrc,
                          input logic [4:0] rd, input logic [31:0] pc4,
                          input logic [31:0] wd, input logic [31:0] alu);
    exp_t e;
    e.regw = regw; e.memw = memw; e.rsrc = rsrc; e.rd = rd;
    e.pc4 = pc4; e.wd = wd; e.alu = alu;
    exp_q.push_back(e);
  endtask

  task automatic tick_cmp(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s_sb: observed empty scoreboard expected pending entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_alu"},  bus.ALU_ResultM, e.alu);
      check({tag, "_wd"},   bus.WriteDataM, e.wd);
      check({tag, "_regw"}, {31'd0, bus.RegWriteM}, {31'd0, e.regw});
      check({tag, "_memw"}, {31'd0, bus.MemWriteM}, {31'd0, e.memw});
      check({tag, "_rsrc"}, {31'd0, bus.ResultSrcM}, {31'd0, e.rsrc});
      check({tag, "_rd"},   {27'd0, bus.RD_M}, {27'd0, e.rd});
      check({tag, "_pc4"},  bus.PCPlus4M, e.pc4);
    end
  endtask

  initial begin
    int cycles;
    compared   = 0;
    mismatched = 0;
    rst = 1'b0;
    set_idle();

    // Reset holds EX/MEM at zero even with live E-stage inputs.
    op(ALU_ADD, 32'd5, 32'd7, 1'b1, 5'd3, 32'h104);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_alu",  bus.ALU_ResultM, 32'd0);
    check("rst_regw", {31'd0, bus.RegWriteM}, 32'd0);
    check("rst_rd",   {27'd0, bus.RD_M}, 32'd0);
    check("rst_busy", {31'd0, bus.BusyE}, 32'd0);
    rst = 1'b1;

    // ADD 5+7.
    expect_m(1'b1, 1'b0, 1'b0, 5'd3, 32'h104, 32'd7, 32'd12);
    tick_cmp("add");

    // SUB with A forwarded from M (12) minus 2.
    op(ALU_SUB, 32'd99, 32'd2, 1'b1, 5'd4, 32'h108);
    bus.ForwardAE = FWD_M;
    expect_m(1'b1, 1'b0, 1'b0, 5'd4, 32'h108, 32'd2, 32'd10);
    tick_cmp("sub_fwdm");

    // B forwarded from W (9): store data is the forwarded value.
    op(ALU_SUB, 32'd20, 32'd55, 1'b0, 5'd0, 32'h10C);
    bus.ForwardAE = FWD_RF;
    bus.ForwardBE = FWD_W;
    bus.ResultW   = 32'd9;
    bus.MemWriteE = 1'b1;
    expect_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h10C, 32'd9, 32'd11);
    tick_cmp("sub_fwdw");

    // Select 11 behaves as register file.
    op(ALU_ADD, 32'd20, 32'd6, 1'b1, 5'd7, 32'h110);
    bus.MemWriteE  = 1'b0;
    bus.ForwardBE  = FWD_RF_ALT;
    bus.ResultSrcE = 1'b1;
    expect_m(1'b1, 1'b0, 1'b1, 5'd7, 32'h110, 32'd6, 32'd26);
    tick_cmp("fwd11");

    // A forwarded from W.
    set_idle();
    op(ALU_ADD, 32'd0, 32'd1, 1'b1, 5'd8, 32'h114);
    bus.ForwardAE = FWD_W;
    bus.ResultW   = 32'd100;
    expect_m(1'b1, 1'b0, 1'b0, 5'd8, 32'h114, 32'd1, 32'd101);
    tick_cmp("fwdaw");

    // Branch taken: 3-3 == 0.
    set_idle();
    op(ALU_SUB, 32'd3, 32'd3, 1'b0, 5'd0, 32'h104);
    bus.BranchE   = 1'b1;
    bus.PCE       = 32'h100;
    bus.Imm_Ext_E = 32'h20;
    #1;
    check("br_taken_src", {31'd0, bus.PCSrcE}, 32'd1);
    check("br_target",    bus.PCTargetE, 32'h120);
    expect_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h104, 32'd3, 32'd0);
    tick_cmp("br_eq");

    // Branch not taken: 3-4 != 0.
    bus.RD2_E = 32'd4;
    #1;
    check("br_nt_src", {31'd0, bus.PCSrcE}, 32'd0);
    expect_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h104, 32'd4, 32'hFFFF_FFFF);
    tick_cmp("br_ne");

    // Jump always redirects.
    set_idle();
    op(ALU_ADD, 32'd1, 32'd1, 1'b1, 5'd1, 32'h204);
    bus.JumpE = 1'b1;
    bus.PCE = 32'hFFFF_FFF0;
    bus.Imm_Ext_E = 32'h20;
    #1;
    check("jmp_src",    {31'd0, bus.PCSrcE}, 32'd1);
    check("jmp_target", bus.PCTargetE, 32'h0000_0010);
    expect_m(1'b1, 1'b0, 1'b0, 5'd1, 32'h204, 32'd1, 32'd2);
    tick_cmp("jmp");

    // Wrap, signed compare, shift-amount truncation, logic ops.
    set_idle();
    op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd2, 32'h0);
    expect_m(1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'd1, 32'd0);
    tick_cmp("add_wrap");
    op(ALU_SLT, 32'h8000_0000, 32'd1, 1'b1, 5'd2, 32'h0);
    expect_m(1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'd1, 32'd1);
    tick_cmp("slt_neg");
    op(ALU_SLT, 32'd1, 32'h8000_0000, 1'b1, 5'd2, 32'h0);
    expect_m(1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'h8000_0000, 32'd0);
    tick_cmp("slt_pos");
    op(ALU_SLL, 32'd1, 32'hAB, 1'b1, 5'd5, 32'h0);
    bus.ALUSrcE   = 1'b1;
    bus.Imm_Ext_E = 32'd33;
    expect_m(1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'hAB, 32'd2);
    tick_cmp("sll33");
    bus.ALUSrcE = 1'b0;
    op(ALU_AND, 32'hF0F0, 32'hFF00, 1'b1, 5'd6, 32'h0);
    expect_m(1'b1, 1'b0, 1'b0, 5'd6, 32'h0, 32'hFF00, 32'hF000);
    tick_cmp("and");
    op(ALU_OR, 32'hF0F0, 32'hFF00, 1'b1, 5'd6, 32'h0);
    expect_m(1'b1, 1'b0, 1'b0, 5'd6, 32'h0, 32'hFF00, 32'hFFF0);
    tick_cmp("or");
    op(ALU_XOR, 32'hF0F0, 32'hFF00, 1'b1, 5'd6, 32'h0);
    expect_m(1'b1, 1'b0, 1'b0, 5'd6, 32'h0, 32'hFF00, 32'h0FF0);
    tick_cmp("xor");

    // MUL 0xFFFFFFFF * 3, with a jump request that must be suppressed.
    set_idle();
    op(ALU_MUL, 32'hFFFF_FFFF, 32'd3, 1'b1, 5'd9, 32'h300);
    bus.JumpE = 1'b1;
    #1;
    check("mul_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);
`ifdef EX_MUL_EN
    cycles = 0;
    while (bus.BusyE && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      check("mul_bubble_regw", {31'd0, bus.RegWriteM}, 32'd0);
      check("mul_bubble_alu",  bus.ALU_ResultM, 32'd0);
    end
    check("mul_busy_cycles", cycles, 32'd33);
    expect_m(1'b1, 1'b0, 1'b0, 5'd9, 32'h300, 32'd3, 32'hFFFF_FFFD);
    tick_cmp("mul");

    // Reset during BUSY aborts the multiply.
    set_idle();
    op(ALU_MUL, 32'd7, 32'd6, 1'b1, 5'd10, 32'h400);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    check("mulrst_busy_before", {31'd0, bus.BusyE}, 32'd1);
    rst = 1'b0;
    #1;
    check("mulrst_alu",  bus.ALU_ResultM, 32'd0);
    check("mulrst_regw", {31'd0, bus.RegWriteM}, 32'd0);
    op(ALU_ADD, 32'd5, 32'd7, 1'b1, 5'd11, 32'h404);
    #1;
    rst = 1'b1;
    #1;
    check("mulrst_busy_after", {31'd0, bus.BusyE}, 32'd0);
    expect_m(1'b1, 1'b0, 1'b0, 5'd11, 32'h404, 32'd7, 32'd12);
    tick_cmp("mulrst_add");
    op(ALU_ADD, 32'd1, 32'd1, 1'b1, 5'd12, 32'h408);
    expect_m(1'b1, 1'b0, 1'b0, 5'd12, 32'h408, 32'd1, 32'd2);
    tick_cmp("mulrst_add2");
`else
    cycles = 0;
    check("mul_busy_off", {31'd0, bus.BusyE}, 32'd0);
    expect_m(1'b1, 1'b0, 1'b0, 5'd9, 32'h300, 32'd3, 32'd0);
    tick_cmp("mul_off");
`endif

    // Asynchronous clear of a populated EX/MEM register, no clock edge.
    set_idle();
    op(ALU_ADD, 32'd40, 32'd2, 1'b1, 5'd13, 32'h500);
    expect_m(1'b1, 1'b0, 1'b0, 5'd13, 32'h500, 32'd2, 32'd42);
    tick_cmp("pre_arst");
    #2;
    rst = 1'b0;
    #1;
    check("arst_alu",  bus.ALU_ResultM, 32'd0);
    check("arst_regw", {31'd0, bus.RegWriteM}, 32'd0);
    check("arst_pc4",  bus.PCPlus4M, 32'd0);
    check("arst_wd",   bus.WriteDataM, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_busy_release", {31'd0, bus.BusyE}, 32'd0);
    expect_m(1'b1, 1'b0, 1'b0, 5'd13, 32'h500, 32'd2, 32'd42);
    tick_cmp("post_arst");

    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have clk, input, 1: clock, rising-edge active.
REQ-002 SHALL have rst, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, each input, 1: decoded E-stage controls.
REQ-004 SHALL have ALUControlE, input, 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLL (shamt [4:0]), 111 MUL.
REQ-005 SHALL have ForwardAE, ForwardBE, input, 2: operand select, 00 register file, 01 ResultW, 10 ALU_ResultM, 11 same as 00.
REQ-006 SHALL have RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, each input, 32: operands, immediate, PC, PC+4, W-stage result.
REQ-007 SHALL have RD_E, input, 5: destination register.
REQ-008 SHALL have PCSrcE, output, 1 and PCTargetE, output, 32: redirect request and target to fetch.
REQ-009 SHALL have BusyE, output, 1: stall request to the hazard unit.
REQ-010 SHALL have RegWriteM, MemWriteM, ResultSrcM, output, 1; RD_M, output, 5; PCPlus4M, WriteDataM, ALU_ResultM, output, 32: EX/MEM register contents.

Function
REQ-011 SrcA/fwdB SHALL be selected per REQ-005; ALU_ResultM is the block's own registered output.
REQ-012 SrcB SHALL be Imm_Ext_E when ALUSrcE=1, else fwdB; WriteDataM SHALL capture fwdB.
REQ-013 ALU SHALL be combinational 32-bit; ADD/SUB wrap modulo 2^32; Zero = (result==0).
REQ-014 PCTargetE SHALL be PCE+Imm_Ext_E modulo 2^32, combinational.
REQ-015 PCSrcE SHALL be JumpE | (BranchE & Zero), combinational, forced 0 while ALUControlE=111.
REQ-016 When BusyE=0, every rising edge SHALL load all EX/MEM outputs from E-stage values (latency 1).
REQ-017 When BusyE=1, each rising edge SHALL load a bubble: RegWriteM=0, MemWriteM=0, all other EX/MEM fields 0.
REQ-018 Hazard unit holds E-stage inputs stable while BusyE=1; block behaviour with changing inputs while BusyE=1 is unspecified.

Reset
REQ-019 rst=0 SHALL immediately clear all EX/MEM outputs to 0, multiplier FSM to IDLE, counter and accumulators to 0.
REQ-020 Reset asserted mid-multiply SHALL abort it; no partial product SHALL reach ALU_ResultM.
REQ-021 After rst release, BusyE SHALL be 0 unless ALUControlE=111.

Configuration
REQ-022 With EX_MUL_EN defined: shift-add multiplier FSM IDLE->BUSY->DONE->IDLE SHALL be present.
REQ-023 IDLE with ALUControlE=111: latch SrcA, SrcB (forwarded values valid that cycle), BusyE=1, go BUSY.
REQ-024 BUSY: one multiplier bit per cycle, 32 cycles, BusyE=1; after count 31 go DONE.
REQ-025 DONE: BusyE=0, ALU result = low 32 bits of product, captured per REQ-016; next state IDLE.
REQ-026 Net MUL timing: BusyE high exactly 33 consecutive cycles, result in ALU_ResultM after next edge.
REQ-027 Without EX_MUL_EN: no FSM, BusyE tied 0, code 111 SHALL yield ALU result 0.

Structure
REQ-028 Shared package riscv_pkg SHALL hold ALU control codes, forward-select codes, XLEN=32.
REQ-029 Multiplier SHALL be sub-module seq_multiplier (start, operands, busy, done, product), instantiated only under EX_MUL_EN.

Verification
REQ-030 ADD RD1=5, RD2=7, fwd 00 -> ALU_ResultM=12 after one edge, RegWriteM mirrors RegWriteE.
REQ-031 Back-to-back: ADD result 12 in M, next SUB with ForwardAE=10, RD2=2 -> ALU_ResultM=10; ForwardBE=01, ResultW=9 -> WriteDataM=9.
REQ-032 Branch: BranchE=1, SUB of 3-3, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120; with 3-4 -> PCSrcE=0.
REQ-033 EX_MUL_EN, MUL 0xFFFFFFFF*3 -> BusyE high 33 cycles, RegWriteM=0 throughout, then ALU_ResultM=0xFFFFFFFD.
REQ-034 rst=0 at BUSY cycle 10 -> outputs 0 immediately, BusyE=0 after release with ADD in E; no product written.
REQ-035 Overflow/wrap: ADD 0xFFFFFFFF+1 -> 0; SLT 0x80000000<1 -> 1; SLL 1 by 33 -> 2.
